mem_port_arbiter: RTL

// Shares the single DPI-backed Memory port between the instruction fetch unit (IFU) and the

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU,
// with programmable access latency and valid/ready responses.
module mem_port_arbiter #(
  parameter int LATENCY = 1,
  parameter bit RR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_len,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_rsp_valid,
  input  logic        lsu_rsp_ready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  mem_wen,
  output logic [1:0]  mem_ren,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] LAT_M1 =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [1:0] S_AFTER_ACCEPT =
    (LATENCY > 0) ? S_WAIT : S_ACC;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_own;
  logic        r_last;
  logic        r_we;
  logic [1:0]  r_len;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_ifu_rdata;
  logic [31:0] r_lsu_rdata;

  logic w_idle;
  logic w_acc;
  logic w_rsp;
  logic w_gnt_lsu;
  logic w_load;
  logic w_store;
  logic w_own_rdy;

  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = (r_state == S_ACC);
  assign w_rsp  = (r_state == S_RESP);

  // owner encoding: 1 = LSU, 0 = IFU
  assign w_gnt_lsu = lsu_req_valid &
    (~ifu_req_valid | (RR_EN ? ~r_last : 1'b1));

  assign lsu_req_ready = w_idle & w_gnt_lsu;
  assign ifu_req_ready = w_idle & ifu_req_valid & ~w_gnt_lsu;

  assign w_load  = w_acc & ~r_we & (r_len != 2'b00);
  assign w_store = w_acc &  r_we & (r_len != 2'b00);

  assign mem_ren   = w_load  ? r_len   : 2'b00;
  assign mem_raddr = w_load  ? r_addr  : '0;
  assign mem_wen   = w_store ? r_len   : 2'b00;
  assign mem_waddr = w_store ? r_addr  : '0;
  assign mem_wdata = w_store ? r_wdata : '0;

  assign ifu_rsp_valid = w_rsp & ~r_own;
  assign lsu_rsp_valid = w_rsp &  r_own;
  assign ifu_rdata     = r_ifu_rdata;
  assign lsu_rdata     = r_lsu_rdata;
  assign w_own_rdy = r_own ? lsu_rsp_ready : ifu_rsp_ready;

  // transaction FSM: accept, wait, single access cycle, response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_own       <= 1'b0;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_len       <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ifu_req_ready | lsu_req_ready) begin
            r_own   <= w_gnt_lsu;
            r_last  <= w_gnt_lsu;
            r_we    <= w_gnt_lsu & lsu_we;
            r_len   <= w_gnt_lsu ? lsu_len : 2'b11;
            r_addr  <= w_gnt_lsu ? lsu_addr : ifu_addr;
            r_wdata <= w_gnt_lsu ? lsu_wdata : '0;
            r_cnt   <= LAT_M1;
            r_state <= S_AFTER_ACCEPT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_ACC;
          else r_cnt <= r_cnt - 4'd1;
        end
        S_ACC: begin
          if (r_own) r_lsu_rdata <= w_load ? mem_rdata : '0;
          else       r_ifu_rdata <= w_load ? mem_rdata : '0;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_own_rdy) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
